// File: rtl/comp_fmt_pkg.sv
// Shared constants and types for the comparator frame packer.
//   HDR_TAG : upper nibble of every frame header word
//   BX_MAX  : last bunch-crossing number before the counter wraps to 0
//   ENTRY_W : FIFO entry width, {bx[11:0], G6..G1} = 12 + 48 bits
//   tx_state_e : serializer FSM states
package comp_fmt_pkg;

    localparam logic [3:0]  HDR_TAG = 4'hC;
    localparam int unsigned BX_MAX  = 3563;
    localparam int unsigned ENTRY_W = 60;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StD1,
        StD2,
        StD3
    } tx_state_e;

endpackage

// File: rtl/comp_fifo.sv
// Synchronous single-clock FIFO holding one frame entry per slot.
// Ports:
//   lctclk, lctrst : clock, asynchronous active-high reset
//   push, wdata    : write request and data; ignored when full unless pop on the same edge
//   pop            : read request; ignored when empty
//   rdata          : head entry (valid while !empty)
//   full, empty    : occupancy flags
//   count          : number of stored entries, 0..DEPTH
module comp_fifo #(
    parameter int unsigned WIDTH = 60,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     lctclk,
    input  logic                     lctrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped, so this is safe.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge lctclk or posedge lctrst) begin
        if (lctrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge lctclk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/comp_frame_packer.sv
// Captures the six comparator bytes every LCTCLK cycle, tags non-empty samples
// with the bunch-crossing number, queues them, and serializes each as a 4-word
// frame: {C,bx}, {G2,G1}, {G4,G3}, {G6,G5}.
// Ports:
//   LCTCLK, LCTRST    : 40 MHz clock, asynchronous active-high reset
//   G1C_LV..G6C_LV    : comparator bytes
//   ENABLE            : allow new frames to be queued
//   RESYNC            : zero the BX counter, clear OVFL/NDROP
//   TX_RDY            : downstream ready
//   TX_DATA/VLD/SOF   : frame word, valid, start-of-frame (header word)
//   OVFL, NDROP       : sticky drop flag, saturating drop count
module comp_frame_packer
    import comp_fmt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BX_WIDTH   = 12
) (
    input  logic        LCTCLK,
    input  logic        LCTRST,
    input  logic [7:0]  G1C_LV,
    input  logic [7:0]  G2C_LV,
    input  logic [7:0]  G3C_LV,
    input  logic [7:0]  G4C_LV,
    input  logic [7:0]  G5C_LV,
    input  logic [7:0]  G6C_LV,
    input  logic        ENABLE,
    input  logic        RESYNC,
    input  logic        TX_RDY,
    output logic [15:0] TX_DATA,
    output logic        TX_VLD,
    output logic        TX_SOF,
    output logic        OVFL,
    output logic [7:0]  NDROP
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [BX_WIDTH-1:0] bx_q, sample_bx_q;
    logic [47:0]         sample_q;
    logic                ovfl_q;
    logic [7:0]          ndrop_q;
    tx_state_e           state_q, state_d;

    logic [ENTRY_W-1:0]  entry, head;
    logic                fifo_full, fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic                push_req, push_ok, drop, tx_acc, pop;

    assign entry    = {sample_bx_q[11:0], sample_q};
    assign push_req = ENABLE && (sample_q != '0);
    assign tx_acc   = TX_VLD && TX_RDY;
    assign pop      = (state_q == StD3) && tx_acc;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign drop     = push_req && !push_ok;

    comp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .lctclk (LCTCLK),
        .lctrst (LCTRST),
        .push   (push_ok),
        .pop    (pop),
        .wdata  (entry),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge LCTCLK or posedge LCTRST) begin
        if (LCTRST) begin
            bx_q        <= '0;
            sample_bx_q <= '0;
            sample_q    <= '0;
            ovfl_q      <= 1'b0;
            ndrop_q     <= '0;
            state_q     <= StIdle;
        end else begin
            sample_q    <= {G6C_LV, G5C_LV, G4C_LV, G3C_LV, G2C_LV, G1C_LV};
            sample_bx_q <= bx_q;
            if (RESYNC || bx_q == BX_WIDTH'(BX_MAX)) bx_q <= '0;
            else                                    bx_q <= bx_q + 1'b1;
            // RESYNC wins over a drop on the same edge.
            if (RESYNC) begin
                ovfl_q  <= 1'b0;
                ndrop_q <= '0;
            end else if (drop) begin
                ovfl_q <= 1'b1;
                if (ndrop_q != 8'hFF) ndrop_q <= ndrop_q + 1'b1;
            end
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (!fifo_empty) state_d = StHdr;
            StHdr:  if (tx_acc) state_d = StD1;
            StD1:   if (tx_acc) state_d = StD2;
            StD2:   if (tx_acc) state_d = StD3;
            // Count the same-edge push so back-to-back frames never idle.
            StD3:   if (tx_acc) state_d = (fifo_count > CW'(1) || push_ok) ? StHdr : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from state and the FIFO head, which stays put
    // until W3 is accepted, so a stall holds the word without extra registers.
    always_comb begin
        TX_DATA = '0;
        TX_VLD  = 1'b0;
        TX_SOF  = 1'b0;
        unique case (state_q)
            StHdr: begin
                TX_VLD  = 1'b1;
                TX_SOF  = 1'b1;
                TX_DATA = {HDR_TAG, head[59:48]};
            end
            StD1: begin
                TX_VLD  = 1'b1;
                TX_DATA = head[15:0];
            end
            StD2: begin
                TX_VLD  = 1'b1;
                TX_DATA = head[31:16];
            end
            StD3: begin
                TX_VLD  = 1'b1;
                TX_DATA = head[47:32];
            end
            default: ;
        endcase
    end

    assign OVFL  = ovfl_q;
    assign NDROP = ndrop_q;

endmodule

// File: tb/tb_comp_frame_packer.sv
module tb_comp_frame_packer;

    logic        LCTCLK = 1'b0;
    logic        LCTRST, ENABLE, RESYNC, TX_RDY;
    logic [7:0]  g1, g2, g3, g4, g5, g6;
    logic [15:0] TX_DATA;
    logic        TX_VLD, TX_SOF, OVFL;
    logic [7:0]  NDROP;

    always #5 LCTCLK = ~LCTCLK;

    comp_frame_packer #(
        .FIFO_DEPTH (16),
        .BX_WIDTH   (12)
    ) dut (
        .LCTCLK  (LCTCLK),
        .LCTRST  (LCTRST),
        .G1C_LV  (g1),
        .G2C_LV  (g2),
        .G3C_LV  (g3),
        .G4C_LV  (g4),
        .G5C_LV  (g5),
        .G6C_LV  (g6),
        .ENABLE  (ENABLE),
        .RESYNC  (RESYNC),
        .TX_RDY  (TX_RDY),
        .TX_DATA (TX_DATA),
        .TX_VLD  (TX_VLD),
        .TX_SOF  (TX_SOF),
        .OVFL    (OVFL),
        .NDROP   (NDROP)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Edge bookkeeping: the sample taken at the coming edge carries
    // (edges since reset or last RESYNC edge) mod 3564.
    int edge_cnt, base_edge;
    always @(posedge LCTCLK or posedge LCTRST) begin
        if (LCTRST) begin
            edge_cnt  <= 0;
            base_edge <= 0;
        end else begin
            edge_cnt <= edge_cnt + 1;
            if (RESYNC) base_edge <= edge_cnt + 1;
        end
    end

    function automatic logic [11:0] exp_bx();
        return 12'((edge_cnt - base_edge) % 3564);
    endfunction

    // Accepted-word monitor
    logic [15:0] wq[$];
    logic        sq[$];
    int          vld_cnt = 0;
    always @(negedge LCTCLK) begin
        if (!LCTRST) begin
            if (TX_VLD) vld_cnt++;
            if (TX_VLD && TX_RDY) begin
                wq.push_back(TX_DATA);
                sq.push_back(TX_SOF);
            end
        end
    end

    task automatic tick();
        @(posedge LCTCLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic set_g(input logic [47:0] g);
        {g6, g5, g4, g3, g2, g1} = g;
    endtask

    // Present g for one sample edge; returns just after that edge.
    task automatic hit(input logic [47:0] g);
        set_g(g);
        tick();
        set_g('0);
    endtask

    task automatic wait_words(input string nm, input int n, input int budget);
        int b = budget;
        while (wq.size() < n && b > 0) begin
            tick();
            b--;
        end
        chk({nm, "_arrived"}, 32'(wq.size() >= n), 32'd1);
    endtask

    task automatic wait_sof(input string nm);
        int b = 20;
        while (!(TX_VLD && TX_SOF) && b > 0) begin
            tick();
            b--;
        end
        chk(nm, 32'(TX_VLD && TX_SOF), 32'd1);
    endtask

    task automatic check_frame(input string nm, input logic [11:0] bx,
                               input logic [15:0] w1, input logic [15:0] w2,
                               input logic [15:0] w3);
        logic [15:0] ew [4];
        logic [15:0] w;
        logic [3:0]  sofs;
        ew[0] = {4'hC, bx};
        ew[1] = w1;
        ew[2] = w2;
        ew[3] = w3;
        if (wq.size() < 4) begin
            chk({nm, "_len"}, 32'(wq.size()), 32'd4);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            w = wq.pop_front();
            sofs[3-i] = sq.pop_front();
            chk($sformatf("%s_w%0d", nm, i), 32'(w), 32'(ew[i]));
        end
        chk({nm, "_sof"}, 32'(sofs), 32'(4'b1000));
    endtask

    typedef struct {
        string       name;
        logic        en;
        logic [47:0] g;     // {G6,G5,G4,G3,G2,G1}
        logic        frame;
        logic [15:0] w1, w2, w3;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        vt [6];
        logic [11:0] bx, bx2;
        logic        stable;
        int          gaps, b;
        logic [3:0]  x;

        vt[0] = '{"all_bytes", 1'b1, 48'h66_55_44_33_22_11, 1'b1, 16'h2211, 16'h4433, 16'h6655};
        vt[1] = '{"g6_msb",    1'b1, 48'h80_00_00_00_00_00, 1'b1, 16'h0000, 16'h0000, 16'h8000};
        vt[2] = '{"g3_lsb",    1'b1, 48'h00_00_00_01_00_00, 1'b1, 16'h0000, 16'h0001, 16'h0000};
        vt[3] = '{"all_ones",  1'b1, 48'hFF_FF_FF_FF_FF_FF, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vt[4] = '{"disabled",  1'b0, 48'hA5_A5_A5_A5_A5_A5, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vt[5] = '{"g2_g5",     1'b1, 48'h00_C3_00_00_5A_00, 1'b1, 16'h5A00, 16'h0000, 16'h00C3};

        LCTRST = 1'b1;
        ENABLE = 1'b1;
        RESYNC = 1'b0;
        TX_RDY = 1'b1;
        set_g('0);
        repeat (3) tick();
        chk("rst_vld",   32'(TX_VLD),  32'd0);
        chk("rst_sof",   32'(TX_SOF),  32'd0);
        chk("rst_data",  32'(TX_DATA), 32'd0);
        chk("rst_ovfl",  32'(OVFL),    32'd0);
        chk("rst_ndrop", 32'(NDROP),   32'd0);
        LCTRST = 1'b0;

        // Quiet inputs: nothing must be sent; the BX counter wraps once.
        repeat (4000) tick();
        chk("idle_no_vld", 32'(vld_cnt), 32'd0);
        bx = exp_bx();
        hit(48'h00_00_00_00_00_01);
        wait_words("wrap", 4, 20);
        check_frame("wrap", bx, 16'h0001, 16'h0000, 16'h0000);

        // Single hit sampled at BX 100, cycle-exact presentation.
        b = 4000;
        while (exp_bx() != 12'd100 && b > 0) begin
            tick();
            b--;
        end
        chk("bx100_reached", 32'(exp_bx()), 32'd100);
        hit(48'h00_00_00_00_00_11);
        chk("lat_e0", 32'({TX_VLD, TX_SOF, TX_DATA}), 32'h0_0000);
        tick();
        chk("lat_e1", 32'({TX_VLD, TX_SOF, TX_DATA}), 32'h0_0000);
        tick();
        chk("lat_w0", 32'({TX_VLD, TX_SOF, TX_DATA}), 32'h3_C064);
        tick();
        chk("lat_w1", 32'({TX_VLD, TX_SOF, TX_DATA}), 32'h2_0011);
        tick();
        chk("lat_w2", 32'({TX_VLD, TX_SOF, TX_DATA}), 32'h2_0000);
        tick();
        chk("lat_w3", 32'({TX_VLD, TX_SOF, TX_DATA}), 32'h2_0000);
        tick();
        chk("lat_end", 32'(TX_VLD), 32'd0);
        repeat (4) tick();
        wq.delete();
        sq.delete();

        // Table of isolated single-cycle hits.
        for (int i = 0; i < 6; i++) begin
            bx = exp_bx();
            ENABLE = vt[i].en;
            hit(vt[i].g);
            tick();             // push decision edge still sees this ENABLE
            ENABLE = 1'b1;
            if (vt[i].frame) begin
                wait_words(vt[i].name, 4, 20);
                check_frame(vt[i].name, bx, vt[i].w1, vt[i].w2, vt[i].w3);
            end else begin
                repeat (12) tick();
                chk({vt[i].name, "_none"}, 32'(wq.size()), 32'd0);
            end
            repeat (3) tick();
            wq.delete();
            sq.delete();
        end

        // Stall in D1 for 10 cycles with a second hit arriving meanwhile.
        bx = exp_bx();
        hit(48'h0F_0E_0D_0C_0B_0A);
        wait_sof("stall_sof");
        tick();
        chk("stall_d1", 32'({TX_VLD, TX_SOF, TX_DATA}), 32'h2_0B0A);
        TX_RDY = 1'b0;
        stable = 1'b1;
        bx2 = exp_bx();
        set_g(48'h00_00_00_00_77_00);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) set_g('0);
            if (!(TX_VLD && !TX_SOF && TX_DATA == 16'h0B0A)) stable = 1'b0;
        end
        chk("stall_hold", 32'(stable), 32'd1);
        TX_RDY = 1'b1;
        wait_words("stall", 8, 40);
        check_frame("stall_f1", bx, 16'h0B0A, 16'h0D0C, 16'h0F0E);
        check_frame("stall_f2", bx2, 16'h7700, 16'h0000, 16'h0000);
        repeat (10) tick();
        chk("stall_extra", 32'(wq.size()), 32'd0);
        wq.delete();
        sq.delete();

        // Hit every cycle: sustained draining, overflow at exact edge, saturation.
        bx = exp_bx();
        gaps = 0;
        for (int i = 0; i < 500; i++) begin
            x = 4'(i);
            set_g({4'h6, x, 4'h5, x, 4'h4, x, 4'h3, x, 4'h2, x, 4'h1, x});
            tick();
            if (i >= 2 && !TX_VLD) gaps++;
            if (i == 20) begin
                chk("full_no_drop_ovfl",  32'(OVFL),  32'd0);
                chk("full_no_drop_ndrop", 32'(NDROP), 32'd0);
            end
            if (i == 21) begin
                chk("first_drop_ovfl",  32'(OVFL),  32'd1);
                chk("first_drop_ndrop", 32'(NDROP), 32'd1);
            end
        end
        set_g('0);
        chk("sustain_gaps", 32'(gaps), 32'd0);
        chk("sat_ovfl",  32'(OVFL),  32'd1);
        chk("sat_ndrop", 32'(NDROP), 32'd255);
        check_frame("burst_first", bx, 16'h2010, 16'h4030, 16'h6050);
        b = 200;
        while (TX_VLD && b > 0) begin
            tick();
            b--;
        end
        chk("burst_drained", 32'(TX_VLD), 32'd0);
        repeat (3) tick();
        wq.delete();
        sq.delete();

        // RESYNC at BX 2000.
        b = 4000;
        while (exp_bx() != 12'd2000 && b > 0) begin
            tick();
            b--;
        end
        chk("bx2000_reached", 32'(exp_bx()), 32'd2000);
        RESYNC = 1'b1;
        tick();
        RESYNC = 1'b0;
        chk("resync_ovfl",  32'(OVFL),  32'd0);
        chk("resync_ndrop", 32'(NDROP), 32'd0);
        hit(48'h00_00_00_00_00_22);
        wait_words("resync", 4, 20);
        check_frame("resync", 12'h000, 16'h0022, 16'h0000, 16'h0000);
        repeat (3) tick();
        wq.delete();
        sq.delete();

        // Reset during D2 with a second entry still queued.
        set_g(48'h00_00_00_00_00_31);
        tick();
        set_g(48'h00_00_00_00_00_32);
        tick();
        set_g('0);
        wait_sof("rst_mid_sof");
        tick();
        tick();
        chk("rst_mid_d2", 32'({TX_VLD, TX_DATA}), 32'h1_0000);
        #2;
        LCTRST = 1'b1;
        #1;
        chk("rst_mid_vld",  32'(TX_VLD),  32'd0);
        chk("rst_mid_data", 32'(TX_DATA), 32'd0);
        tick();
        tick();
        LCTRST = 1'b0;
        wq.delete();
        sq.delete();
        repeat (10) tick();
        chk("rst_mid_empty", 32'(wq.size()), 32'd0);
        bx = exp_bx();
        hit(48'h00_00_00_00_44_33);
        wait_words("post_rst", 4, 20);
        check_frame("post_rst", bx, 16'h4433, 16'h0000, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
